// File: rtl/rep_word_serializer.sv
// Serializes one WIDTH-bit word per valid/ready handshake into a single-wire frame:
// start bit (0), data MSB-first, optional even-parity bit (SERIALIZER_PARITY_EN), stop bit (1).
module rep_word_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(DIV) + 1;
  localparam int unsigned BIT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef SERIALIZER_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             din_ready_q, din_ready_d;
  logic             period_end_c;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign period_end_c = (cnt_q == CNT_W'(DIV - 1));

  // Next-state, counters and the registered line levels derived from the next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (din_valid && din_ready_q) begin
          state_d  = S_START;
          shreg_d  = din;
          cnt_d    = '0;
          bit_d    = '0;
`ifdef SERIALIZER_PARITY_EN
          parity_d = ^din;
`endif
        end
      end
      S_START: begin
        if (period_end_c) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (period_end_c) begin
          cnt_d   = '0;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            bit_d   = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: begin
        if (period_end_c) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (period_end_c) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Line level for the upcoming cycle; DATA shows the MSB of the (possibly just shifted) word
    case (state_d)
      S_START:  sout_d = 1'b0;
      S_DATA:   sout_d = shreg_d[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: sout_d = parity_d;
`endif
      default:  sout_d = 1'b1;
    endcase

    busy_d      = (state_d != S_IDLE);
    din_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      sout_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      din_ready_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      sout_q      <= sout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      din_ready_q <= din_ready_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign din_ready = din_ready_q;
  assign sout      = sout_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
